inject_ctrl: RTL
================

# inject_ctrl

Local injection controller for the Chipper deflection router. It buffers flits from the local processing element (PE) in a small FIFO and watches the four router input flits each cycle. When an input slot is free, it injects the FIFO head into that slot. It raises a starvation flag when the head has waited too long. It sits between the PE network interface and the router's injector stage.

## Interface
- `FLIT_W`, default 10: flit width. Bit `FLIT_W-1` is the valid bit; the remaining bits are payload and destination.
- `DEPTH`, default 4: FIFO depth in flits, power of two, ≥2.
- `STARVE_MAX`, default 15: wait-cycle threshold for `starve`, ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pe_flit`  in  FLIT_W  flit offered by the PE.
- `pe_valid`  in  1  PE offers `pe_flit` this cycle.
- `pe_ready`  out  1  FIFO can accept a flit.
- `eastad`, `westad`, `northad`, `southad`  in  FLIT_W each  current router input flits, slot indices 0/1/2/3 respectively.
- `inj_flit`  out  FLIT_W  flit being injected.
- `inj_valid`  out  1  `inj_flit` is valid this cycle.
- `inj_slot`  out  2  index of the input slot being filled (0 east, 1 west, 2 north, 3 south).
- `starve`  out  1  head flit has been blocked for `STARVE_MAX` consecutive cycles.

## Operation
- A router input slot is free when its valid bit `[FLIT_W-1]` is anything other than 1'b1; 0, x and z all count as free.
- FIFO:
  - Circular buffer with read/write pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Push: on an edge where `pe_valid && pe_ready`, `pe_flit` is written at the write pointer and the write pointer increments.
- `pe_ready` = (count != DEPTH). It is combinational from the registered count only and does not depend on a same-cycle pop.
- Injection decision, made each edge:
  - Inject when count != 0 and at least one slot is free.
  - On injection: `inj_flit` <= head flit with bit `[FLIT_W-1]` forced to 1, `inj_valid` <= 1, `inj_slot` <= lowest-index free slot (fixed priority east > west > north > south). The head is popped.
  - Otherwise: `inj_valid` <= 0, and `inj_flit` and `inj_slot` hold their previous values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- A push into an empty FIFO is not bypassed. The flit becomes injectable on the following edge.
- Starvation counter, width log2(STARVE_MAX)+1:
  - Clears when the FIFO is empty or an injection occurs.
  - Otherwise increments each edge where count != 0 and no slot is free.
  - Saturates at `STARVE_MAX`.
- `starve` = (counter == STARVE_MAX), registered.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - count, pointers and starvation counter = 0.
  - `inj_valid` = 0, `inj_flit` = 0, `inj_slot` = 0, `starve` = 0.
  - `pe_ready` = 1.
- Reset asserted mid-operation discards all FIFO contents. No partial injection is emitted.
- Slot availability is sampled in the router input stage. The registered `inj_*` outputs are merged one stage later, so the chosen slot is guaranteed empty there.
- Latency: a flit pushed at edge k appears on `inj_valid`/`inj_flit` no earlier than after edge k+1. With a slot free every cycle, a full FIFO drains one flit per cycle.
- Full FIFO: `pe_ready` = 0. `pe_ready` rises the cycle after a pop edge.
- Empty FIFO: `inj_valid` = 0 regardless of slot state, and the starvation counter is held at 0.
- `starve` rises after the `STARVE_MAX`-th consecutive blocked edge. It falls on the edge that injects or empties the FIFO.

## Test plan
- Reset, then push `0000100000` while all inputs carry valid bit 0 → `pe_ready` = 1 throughout; after the second edge `inj_valid` = 1, `inj_flit` = `1000100000`, `inj_slot` = 0.
- East = `1000100001`, west = `1000011100`, north = `0000001000`, south = `1000000101`, one flit queued → `inj_slot` = 2.
- Hold all four inputs valid, push 4 flits → `pe_ready` = 0 after the 4th push; a 5th `pe_valid` is not accepted. Then free the south slot → 4 consecutive injections, each with `inj_slot` = 3, in push order.
- All inputs valid with one flit queued → `starve` = 1 after 15 blocked edges (default `STARVE_MAX`); free the east slot → injection with `inj_slot` = 0, and `starve` = 0 on the same edge.
- FIFO at count 3 with pushes every cycle and a slot free every cycle → count stays 3, output order matches push order, and pointers wrap past DEPTH correctly.
- Assert `rst_n` low mid-stream with 2 flits queued → outputs go to reset values immediately; after release, `inj_valid` stays 0 until a new push.

Source files
------------

// File: rtl/inject_ctrl.sv
// Local injection controller: buffers PE flits in a small FIFO and
// injects the head flit into the lowest-index free router input slot.
module inject_ctrl #(
    parameter int FLIT_W     = 10,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] pe_flit,
    input  logic              pe_valid,
    output logic              pe_ready,
    input  logic [FLIT_W-1:0] eastad,
    input  logic [FLIT_W-1:0] westad,
    input  logic [FLIT_W-1:0] northad,
    input  logic [FLIT_W-1:0] southad,
    output logic [FLIT_W-1:0] inj_flit,
    output logic              inj_valid,
    output logic [1:0]        inj_slot,
    output logic              starve
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic [SW-1:0]     wait_cnt;
    logic [SW-1:0]     wait_nxt;
    logic [3:0]        free;
    logic [1:0]        sel;
    logic              push;
    logic              pop;

    // A slot is free unless its valid bit is a definite 1 (x/z count as free)
    always_comb begin
        free    = '0;
        free[0] = (eastad[FLIT_W-1]  !== 1'b1);
        free[1] = (westad[FLIT_W-1]  !== 1'b1);
        free[2] = (northad[FLIT_W-1] !== 1'b1);
        free[3] = (southad[FLIT_W-1] !== 1'b1);
    end

    // Fixed-priority pick: east > west > north > south
    always_comb begin
        sel = 2'd0;
        priority case (1'b1)
            free[0]: sel = 2'd0;
            free[1]: sel = 2'd1;
            free[2]: sel = 2'd2;
            free[3]: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    assign pe_ready = (count != FULL);
    assign push     = pe_valid && pe_ready;
    assign pop      = (count != '0) && (|free);

    // Starvation count: cleared on empty or inject, saturating while blocked
    always_comb begin
        wait_nxt = wait_cnt;
        if ((count == '0) || pop) begin
            wait_nxt = '0;
        end else if (wait_cnt != SMAX) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    // Storage array has no reset; pointers and count define its contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pe_flit;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered injection outputs; flit and slot hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_flit  <= '0;
            inj_slot  <= '0;
            inj_valid <= 1'b0;
        end else begin
            inj_valid <= pop;
            if (pop) begin
                inj_flit <= {1'b1, mem[rd_ptr][FLIT_W-2:0]};
                inj_slot <= sel;
            end
        end
    end

    // Starvation counter and its registered flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == SMAX);
        end
    end

endmodule
